// File: rtl/gate_bist_pkg.sv
// gate_bist_pkg: shared state encoding, polynomials and LFSR/MISR step functions
// for the gate-model BIST harness and its reference model.
package gate_bist_pkg;
  localparam int IN_W_DEF = 19;
  localparam int OUT_W_DEF = 9;
  localparam int SIG_W_DEF = 16;
  // x^19+x^6+x^2+x+1 feedback taps: s[18], s[5], s[1], s[0]
  localparam logic [IN_W_DEF-1:0] LFSR_TAPS = 19'h40023;
  localparam logic [SIG_W_DEF-1:0] MISR_POLY = 16'h1021;
  typedef enum logic [1:0] {IDLE, APPLY, CAPTURE, FINISH} state_e;
  function automatic logic [IN_W_DEF-1:0] lfsr_step(input logic [IN_W_DEF-1:0] s);
    return {s[IN_W_DEF-2:0], ^(s & LFSR_TAPS)};
  endfunction
  function automatic logic [SIG_W_DEF-1:0] misr_step(input logic [SIG_W_DEF-1:0] m,
                                                     input logic [SIG_W_DEF-1:0] r);
    return {m[SIG_W_DEF-2:0], 1'b0} ^ (m[SIG_W_DEF-1] ? MISR_POLY : '0) ^ r;
  endfunction
endpackage

// File: rtl/gate_bist_misr.sv
// gate_bist_misr: signature register; load restores the seed, step folds in one response.
module gate_bist_misr
  import gate_bist_pkg::*;
#(
  parameter int SIG_W = SIG_W_DEF,
  parameter logic [SIG_W-1:0] SEED = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [SIG_W-1:0] resp_i,
  output logic [SIG_W-1:0] sig_o
);
  logic [SIG_W-1:0] sig_q, sig_d;
  always_comb sig_d = load_i ? SEED : step_i ? misr_step(sig_q, resp_i) : sig_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= SEED;
    else sig_q <= sig_d;
  end
  assign sig_o = sig_q;
endmodule

// File: rtl/gate_model_bist.sv
// gate_model_bist: drives a combinational gate model from an LFSR, compacts its
// responses in a MISR and compares the final signature against a golden value.
module gate_model_bist
  import gate_bist_pkg::*;
#(
  parameter int IN_W = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int SIG_W = SIG_W_DEF,
  parameter int PAT_CNT = 256,
  parameter logic [IN_W-1:0] LFSR_SEED = 19'h00001,
  parameter logic [SIG_W-1:0] MISR_SEED = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [SIG_W-1:0] golden_sig,
  output logic [IN_W-1:0]  stim_o,
  input  logic [OUT_W-1:0] resp_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [15:0]      pat_idx
);
  // an all-zero seed would lock the LFSR, so it is replaced by 1
  localparam logic [IN_W-1:0] SEED = (LFSR_SEED == '0) ? IN_W'(1) : LFSR_SEED;
  localparam logic [15:0] LAST = 16'(PAT_CNT - 1);
  state_e state_q, state_d;
  logic [IN_W-1:0] stim_q, stim_d;
  logic [15:0] idx_q, idx_d;
  logic [SIG_W-1:0] gold_q, gold_d;
  logic done_q, done_d, pass_q, pass_d;
  logic go, kill, step;
  always_comb begin
    go = (state_q == IDLE) && start;
    kill = (state_q != IDLE) && abort;
    step = (state_q == CAPTURE) && !kill;
    state_d = state_q;
    stim_d = stim_q;
    idx_d = idx_q;
    gold_d = gold_q;
    done_d = done_q;
    pass_d = pass_q;
    if (go) begin
      state_d = APPLY;
      stim_d = SEED;
      idx_d = '0;
      gold_d = golden_sig;
      done_d = 1'b0;
      pass_d = 1'b0;
    end else if (kill) begin
      state_d = IDLE;
    end else if (state_q == APPLY) begin
      state_d = CAPTURE;
    end else if (state_q == CAPTURE) begin
      state_d = (idx_q == LAST) ? FINISH : APPLY;
      stim_d = (idx_q == LAST) ? stim_q : lfsr_step(stim_q);
      idx_d = (idx_q == LAST) ? idx_q : idx_q + 16'd1;
    end else if (state_q == FINISH) begin
      state_d = IDLE;
      done_d = 1'b1;
      pass_d = (signature == gold_q);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stim_q <= '0;
      idx_q <= '0;
      gold_q <= '0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stim_q <= stim_d;
      idx_q <= idx_d;
      gold_q <= gold_d;
      done_q <= done_d;
      pass_q <= pass_d;
    end
  end
  gate_bist_misr #(.SIG_W(SIG_W), .SEED(MISR_SEED)) u_misr (
    .clk(clk),
    .rst_n(rst_n),
    .load_i(go),
    .step_i(step),
    .resp_i(SIG_W'(resp_i)),
    .sig_o(signature)
  );
  assign stim_o = stim_q;
  assign pat_idx = idx_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign pass = pass_q;
endmodule

// File: tb/tb_gate_model_bist.sv
// tb_gate_model_bist: three harness instances (PAT_CNT 4/1/256) with a queued
// scoreboard checked on every rising done and on every stimulus change.
module tb_gate_model_bist;
  import gate_bist_pkg::*;
  typedef struct {
    logic [15:0] sig;
    logic        pass;
    int          cyc;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, fault = 1'b0;
  int cyc = 0, errs = 0, checks = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  logic st_a, ab_a, busy_a, done_a, pass_a;
  logic st_b, ab_b, busy_b, done_b, pass_b;
  logic st_c, ab_c, busy_c, done_c, pass_c;
  logic [15:0] g_a, g_b, g_c, sig_a, sig_b, sig_c, idx_a, idx_b, idx_c;
  logic [18:0] stim_a, stim_b, stim_c;
  logic [8:0] r_a, r_b, r_c;
  exp_t qa[$], qb[$], qc[$];
  logic [18:0] sq[$];
  logic pd_a = 1'b0, pd_b = 1'b0, pd_c = 1'b0;
  logic [18:0] ps_a = '0;
  function automatic logic [8:0] gm(input logic [18:0] n);
    return {n[18] ^ n[3] & n[7], ~(n[1] | n[9]), n[4] ^ n[5] ^ n[6], n[10] & n[11] | n[12],
            ~(n[13] ^ n[14]), n[15] | n[16] & n[17], n[0] ^ n[8], ~(n[2] & n[7]), n[1] & n[3] ^ n[18]};
  endfunction
  assign r_a = '0;
  assign r_b = '0;
  assign r_c = gm(stim_c) | {8'd0, fault};
  gate_model_bist #(.PAT_CNT(4), .LFSR_SEED(19'h0)) u_a (
    .clk(clk), .rst_n(rst_n), .start(st_a), .abort(ab_a), .golden_sig(g_a), .stim_o(stim_a),
    .resp_i(r_a), .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a), .pat_idx(idx_a));
  gate_model_bist #(.PAT_CNT(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(st_b), .abort(ab_b), .golden_sig(g_b), .stim_o(stim_b),
    .resp_i(r_b), .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b), .pat_idx(idx_b));
  gate_model_bist #(.PAT_CNT(256)) u_c (
    .clk(clk), .rst_n(rst_n), .start(st_c), .abort(ab_c), .golden_sig(g_c), .stim_o(stim_c),
    .resp_i(r_c), .busy(busy_c), .done(done_c), .pass(pass_c), .signature(sig_c), .pat_idx(idx_c));
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic score(input string n, input exp_t e, input logic [15:0] s, input logic p);
    check({n, "_sig"}, s, e.sig);
    check({n, "_pass"}, p, e.pass);
    check({n, "_done_cyc"}, cyc, e.cyc);
  endtask
  always @(negedge clk) begin
    if (done_a && !pd_a) begin
      if (qa.size() == 0) check("a_spurious_done", done_a, 0);
      else score("a", qa.pop_front(), sig_a, pass_a);
    end
    if (done_b && !pd_b) begin
      if (qb.size() == 0) check("b_spurious_done", done_b, 0);
      else score("b", qb.pop_front(), sig_b, pass_b);
    end
    if (done_c && !pd_c) begin
      if (qc.size() == 0) check("c_spurious_done", done_c, 0);
      else score("c", qc.pop_front(), sig_c, pass_c);
    end
    if (stim_a != ps_a && sq.size() > 0) check("a_stim", stim_a, sq.pop_front());
    pd_a <= done_a;
    pd_b <= done_b;
    pd_c <= done_c;
    ps_a <= stim_a;
  end
  task automatic go(input int w, input logic [15:0] g, input logic [15:0] es, input logic ep,
                    input logic ab, input bit push);
    @(negedge clk);
    case (w)
      0: begin st_a = 1'b1; ab_a = ab; g_a = g; if (push) qa.push_back('{es, ep, cyc + 1 + 9}); end
      1: begin st_b = 1'b1; ab_b = ab; g_b = g; if (push) qb.push_back('{es, ep, cyc + 1 + 3}); end
      default: begin st_c = 1'b1; ab_c = ab; g_c = g; if (push) qc.push_back('{es, ep, cyc + 1 + 513}); end
    endcase
    @(negedge clk);
    {st_a, ab_a, st_b, ab_b, st_c, ab_c} = '0;
    {g_a, g_b, g_c} = '0;
  endtask
  initial begin
    logic [18:0] s;
    logic [15:0] m, mf;
    {st_a, ab_a, st_b, ab_b, st_c, ab_c} = '0;
    {g_a, g_b, g_c} = '0;
    repeat (3) @(negedge clk);
    check("rst_stim", stim_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_pass", pass_a, 0);
    check("rst_sig", sig_a, 16'hFFFF);
    check("rst_idx", idx_a, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", busy_a, 0);
    check("idle_sig", sig_a, 16'hFFFF);
    // seed 0 forced to 1; start pulsed mid-run must not restart the run
    sq.push_back(19'h00001);
    sq.push_back(19'h00003);
    sq.push_back(19'h00006);
    sq.push_back(19'h0000D);
    go(0, 16'h0E1F, 16'h0E1F, 1'b1, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    st_a = 1'b1;
    @(negedge clk);
    st_a = 1'b0;
    repeat (12) @(negedge clk);
    go(0, 16'h0000, 16'h0E1F, 1'b0, 1'b1, 1'b1);
    repeat (12) @(negedge clk);
    sq.push_back(19'h00001);
    sq.push_back(19'h00003);
    sq.push_back(19'h00006);
    go(0, 16'h0E1F, 16'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20 && idx_a != 16'd2; i++) @(negedge clk);
    check("abort_reach_idx", idx_a, 2);
    ab_a = 1'b1;
    @(negedge clk);
    ab_a = 1'b0;
    check("abort_busy", busy_a, 0);
    check("abort_done", done_a, 0);
    check("abort_pass", pass_a, 0);
    check("abort_stim", stim_a, 19'h00006);
    check("abort_sig", sig_a, 16'hCF9F);
    repeat (12) @(negedge clk);
    check("abort_done_hold", done_a, 0);
    go(1, 16'hEFDF, 16'hEFDF, 1'b1, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    go(1, 16'h0000, 16'hEFDF, 1'b0, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    s = 19'h1;
    m = 16'hFFFF;
    mf = 16'hFFFF;
    for (int i = 0; i < 256; i++) begin
      m = misr_step(m, 16'(gm(s)));
      mf = misr_step(mf, 16'(gm(s) | 9'd1));
      s = lfsr_step(s);
    end
    fault = 1'b1;
    go(2, m, mf, 1'b0, 1'b0, 1'b1);
    repeat (520) @(negedge clk);
    fault = 1'b0;
    go(2, m, m, 1'b1, 1'b0, 1'b1);
    repeat (520) @(negedge clk);
    go(2, m, m, 1'b1, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_stim", stim_c, 0);
    check("midrst_busy", busy_c, 0);
    check("midrst_done", done_c, 0);
    check("midrst_pass", pass_c, 0);
    check("midrst_sig", sig_c, 16'hFFFF);
    check("midrst_idx", idx_c, 0);
    check("midrst_done_b", done_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("postrst_busy", busy_c, 0);
    check("postrst_stim", stim_c, 0);
    check("sb_drain", qa.size() + qb.size() + qc.size() + sq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
